// File: rtl/ram_pkg.sv
// Shared constants and helpers for the true dual-port RAM.
package ram_pkg;

    localparam int unsigned READ_FIRST  = 0;
    localparam int unsigned WRITE_FIRST = 1;

    function automatic int unsigned lane_count(input int unsigned data_width,
                                               input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/ram_port_pipe.sv
// Per-port read output stage: optional extra data/valid register with sync reset.
module ram_port_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OUTPUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;

    // Data holds across idle cycles; valid simply follows the stage before.
    always_comb begin
        valid_d = in_valid;
        data_d  = in_valid ? in_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (OUTPUT_REG != 0) ? valid_q : in_valid;
    assign out_data  = (OUTPUT_REG != 0) ? data_q  : in_data;

endmodule

// File: rtl/true_dual_port_ram_sync.sv
// Byte-writable true dual-port synchronous RAM with selectable read-during-write
// behaviour, optional output register and write-collision flag.
module true_dual_port_ram_sync
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned OUTPUT_REG = 0,
    parameter int unsigned READ_MODE  = READ_FIRST
) (
    input  logic                             clockPulse,
    input  logic                             reset,
    input  logic                             enableA,
    input  logic                             enableB,
    input  logic                             writeEnableA,
    input  logic                             writeEnableB,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteEnableA,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteEnableB,
    input  logic [ADDR_WIDTH-1:0]            addressA,
    input  logic [ADDR_WIDTH-1:0]            addressB,
    input  logic [DATA_WIDTH-1:0]            writeDataA,
    input  logic [DATA_WIDTH-1:0]            writeDataB,
    output logic [DATA_WIDTH-1:0]            readDataA,
    output logic [DATA_WIDTH-1:0]            readDataB,
    output logic                             readValidA,
    output logic                             readValidB,
    output logic                             collision
);

    localparam int unsigned LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem_array [DEPTH];

    logic                  acc_a, acc_b;
    logic [LANES-1:0]      wr_mask_a, wr_mask_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b;

    logic                  valid_a_d, valid_a_q, valid_b_d, valid_b_q;
    logic [DATA_WIDTH-1:0] rd_a_d, rd_a_q, rd_b_d, rd_b_q;
    logic                  collision_d, collision_q;

    always_comb begin
        acc_a     = enableA & ~reset;
        acc_b     = enableB & ~reset;
        wr_mask_a = (acc_a & writeEnableA) ? byteEnableA : '0;
        wr_mask_b = (acc_b & writeEnableB) ? byteEnableB : '0;
        old_a     = mem_array[addressA];
        old_b     = mem_array[addressB];
        merged_a  = old_a;
        merged_b  = old_b;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wr_mask_a[i]) merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = writeDataA[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_mask_b[i]) merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = writeDataB[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Each port only ever sees its own write merged in; the other port reads old data.
    always_comb begin
        valid_a_d   = acc_a;
        valid_b_d   = acc_b;
        rd_a_d      = rd_a_q;
        rd_b_d      = rd_b_q;
        if (acc_a) rd_a_d = (READ_MODE == WRITE_FIRST) ? merged_a : old_a;
        if (acc_b) rd_b_d = (READ_MODE == WRITE_FIRST) ? merged_b : old_b;
        collision_d = (|wr_mask_a) & (|wr_mask_b) & (addressA == addressB);
    end

    // Port B lanes are written first so port A wins lanes both ports enable.
    always_ff @(posedge clockPulse) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wr_mask_b[i]) mem_array[addressB][i*BYTE_WIDTH +: BYTE_WIDTH] <= writeDataB[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_mask_a[i]) mem_array[addressA][i*BYTE_WIDTH +: BYTE_WIDTH] <= writeDataA[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_ff @(posedge clockPulse) begin
        if (reset) begin
            valid_a_q   <= 1'b0;
            valid_b_q   <= 1'b0;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            valid_a_q   <= valid_a_d;
            valid_b_q   <= valid_b_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

    ram_port_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) u_pipe_a (
        .clk       (clockPulse),
        .reset     (reset),
        .in_valid  (valid_a_q),
        .in_data   (rd_a_q),
        .out_valid (readValidA),
        .out_data  (readDataA)
    );

    ram_port_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) u_pipe_b (
        .clk       (clockPulse),
        .reset     (reset),
        .in_valid  (valid_b_q),
        .in_data   (rd_b_q),
        .out_valid (readValidB),
        .out_data  (readDataB)
    );

endmodule

// File: tb/tb_true_dual_port_ram_sync.sv
// Directed bench: three RAM instances (default, WRITE_FIRST, OUTPUT_REG=1) on shared stimulus.
module tb_true_dual_port_ram_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b, we_a, we_b;
    logic [1:0]  be_a, be_b;
    logic [5:0]  addr_a, addr_b;
    logic [15:0] wd_a, wd_b;

    logic [15:0] d0_rd_a, d0_rd_b, wf_rd_a, wf_rd_b, or_rd_a, or_rd_b;
    logic        d0_rv_a, d0_rv_b, wf_rv_a, wf_rv_b, or_rv_a, or_rv_b;
    logic        d0_col, wf_col, or_col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    true_dual_port_ram_sync u_d0 (
        .clockPulse(clk), .reset(rst), .enableA(en_a), .enableB(en_b),
        .writeEnableA(we_a), .writeEnableB(we_b), .byteEnableA(be_a), .byteEnableB(be_b),
        .addressA(addr_a), .addressB(addr_b), .writeDataA(wd_a), .writeDataB(wd_b),
        .readDataA(d0_rd_a), .readDataB(d0_rd_b), .readValidA(d0_rv_a), .readValidB(d0_rv_b),
        .collision(d0_col)
    );

    true_dual_port_ram_sync #(.READ_MODE(1)) u_wf (
        .clockPulse(clk), .reset(rst), .enableA(en_a), .enableB(en_b),
        .writeEnableA(we_a), .writeEnableB(we_b), .byteEnableA(be_a), .byteEnableB(be_b),
        .addressA(addr_a), .addressB(addr_b), .writeDataA(wd_a), .writeDataB(wd_b),
        .readDataA(wf_rd_a), .readDataB(wf_rd_b), .readValidA(wf_rv_a), .readValidB(wf_rv_b),
        .collision(wf_col)
    );

    true_dual_port_ram_sync #(.OUTPUT_REG(1)) u_or (
        .clockPulse(clk), .reset(rst), .enableA(en_a), .enableB(en_b),
        .writeEnableA(we_a), .writeEnableB(we_b), .byteEnableA(be_a), .byteEnableB(be_b),
        .addressA(addr_a), .addressB(addr_b), .writeDataA(wd_a), .writeDataB(wd_b),
        .readDataA(or_rd_a), .readDataB(or_rd_b), .readValidA(or_rv_a), .readValidB(or_rv_b),
        .collision(or_col)
    );

    function automatic logic [15:0] pat(input int i);
        logic [7:0] lo;
        lo = 8'(i);
        return {lo ^ 8'hA5, lo};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        be_a = 2'b11; be_b = 2'b11;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0;
        repeat (3) step();
        checks++;
        if ({d0_rd_a, d0_rd_b, d0_rv_a, d0_rv_b, d0_col} !== 35'd0) begin
            errors++; $display("FAIL reset_d0 got %h exp 0", {d0_rd_a, d0_rd_b, d0_rv_a, d0_rv_b, d0_col});
        end
        checks++;
        if ({or_rd_a, or_rd_b, or_rv_a, or_rv_b, or_col} !== 35'd0) begin
            errors++; $display("FAIL reset_or got %h exp 0", {or_rd_a, or_rd_b, or_rv_a, or_rv_b, or_col});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd4; wd_a = 16'hB0CB;
        step();
        checks++;
        if (d0_rv_a !== 1'b1) begin errors++; $display("FAIL write_valid got %b exp 1", d0_rv_a); end
        idle(); en_b = 1'b1; addr_b = 6'd4;
        step();
        checks++;
        if (d0_rd_b !== 16'hB0CB) begin errors++; $display("FAIL basic_rd_b got %h exp b0cb", d0_rd_b); end
        checks++;
        if ({d0_rv_b, d0_rv_a} !== 2'b10) begin errors++; $display("FAIL basic_valid got %b exp 10", {d0_rv_b, d0_rv_a}); end
        checks++;
        if (or_rv_b !== 1'b0) begin errors++; $display("FAIL or_early_valid got %b exp 0", or_rv_b); end
        idle();
        step();
        checks++;
        if ({or_rv_b, or_rd_b} !== {1'b1, 16'hB0CB}) begin
            errors++; $display("FAIL or_latency got %h exp 1b0cb", {or_rv_b, or_rd_b});
        end
        checks++;
        if ({d0_rv_b, d0_rd_b} !== {1'b0, 16'hB0CB}) begin
            errors++; $display("FAIL hold_rd_b got %h exp 0b0cb", {d0_rv_b, d0_rd_b});
        end
    endtask

    task automatic test_byte_en();
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd7; wd_a = 16'h3838;
        step();
        be_a = 2'b01; wd_a = 16'h1C1C;
        step();
        checks++;
        if (d0_rd_a !== 16'h3838) begin errors++; $display("FAIL be_read_first got %h exp 3838", d0_rd_a); end
        checks++;
        if (wf_rd_a !== 16'h381C) begin errors++; $display("FAIL be_write_first got %h exp 381c", wf_rd_a); end
        we_a = 1'b0; be_a = 2'b11;
        step();
        checks++;
        if (d0_rd_a !== 16'h381C) begin errors++; $display("FAIL be_readback got %h exp 381c", d0_rd_a); end
        we_a = 1'b1; be_a = 2'b00; wd_a = 16'hFFFF;
        step();
        we_a = 1'b0; be_a = 2'b11;
        step();
        checks++;
        if (d0_rd_a !== 16'h381C) begin errors++; $display("FAIL be_zero_mask got %h exp 381c", d0_rd_a); end
        idle();
    endtask

    task automatic test_read_mode();
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd8; wd_a = 16'h1111;
        step();
        wd_a = 16'h2222; en_b = 1'b1; addr_b = 6'd8;
        step();
        checks++;
        if (d0_rd_a !== 16'h1111) begin errors++; $display("FAIL rdw_mode0_a got %h exp 1111", d0_rd_a); end
        checks++;
        if (wf_rd_a !== 16'h2222) begin errors++; $display("FAIL rdw_mode1_a got %h exp 2222", wf_rd_a); end
        checks++;
        if ({d0_rd_b, wf_rd_b} !== {16'h1111, 16'h1111}) begin
            errors++; $display("FAIL rdw_cross_b got %h exp 11111111", {d0_rd_b, wf_rd_b});
        end
        idle(); en_a = 1'b1;
        step();
        checks++;
        if (d0_rd_a !== 16'h2222) begin errors++; $display("FAIL rdw_readback got %h exp 2222", d0_rd_a); end
        idle();
    endtask

    task automatic test_collision();
        en_a = 1'b1; en_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
        addr_a = 6'd11; addr_b = 6'd11; wd_a = 16'hAAAA; wd_b = 16'h5555;
        step();
        checks++;
        if (d0_col !== 1'b1) begin errors++; $display("FAIL col_full got %b exp 1", d0_col); end
        idle(); en_a = 1'b1;
        step();
        checks++;
        if ({d0_col, d0_rd_a} !== {1'b0, 16'hAAAA}) begin
            errors++; $display("FAIL col_full_data got %h exp 0aaaa", {d0_col, d0_rd_a});
        end
        en_b = 1'b1; we_a = 1'b1; we_b = 1'b1; be_a = 2'b01; be_b = 2'b10;
        step();
        checks++;
        if (d0_col !== 1'b1) begin errors++; $display("FAIL col_lanes got %b exp 1", d0_col); end
        idle(); en_a = 1'b1;
        step();
        checks++;
        if ({d0_col, d0_rd_a} !== {1'b0, 16'h55AA}) begin
            errors++; $display("FAIL col_lanes_data got %h exp 055aa", {d0_col, d0_rd_a});
        end
        en_b = 1'b1; we_a = 1'b1; we_b = 1'b1; addr_a = 6'd12; addr_b = 6'd12;
        wd_a = 16'h1234; wd_b = 16'h9999;
        step();
        be_a = 2'b10; be_b = 2'b01; wd_a = 16'h4321; wd_b = 16'h8765;
        step();
        checks++;
        if (d0_col !== 1'b1) begin errors++; $display("FAIL col_back_to_back got %b exp 1", d0_col); end
        be_a = 2'b11; wd_a = 16'h0F0F; we_b = 1'b0;
        step();
        checks++;
        if ({d0_col, d0_rd_b} !== {1'b0, 16'h4365}) begin
            errors++; $display("FAIL col_rd_wr got %h exp 04365", {d0_col, d0_rd_b});
        end
        idle();
    endtask

    task automatic test_output_reg();
        en_a = 1'b1; en_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            addr_a = 6'(i); wd_a = pat(i);
            addr_b = 6'(i + 32); wd_b = pat(i + 32);
            step();
        end
        idle();
        for (int i = 0; i < 66; i++) begin
            if (i < 64) begin en_a = 1'b1; addr_a = 6'(i); end
            else en_a = 1'b0;
            step();
            if (i < 64) begin
                checks++;
                if ({d0_rv_a, d0_rd_a} !== {1'b1, pat(i)}) begin
                    errors++; $display("FAIL burst_d0 addr %0d got %h exp %h", i, {d0_rv_a, d0_rd_a}, {1'b1, pat(i)});
                end
            end
            if (i >= 1 && i <= 64) begin
                checks++;
                if ({or_rv_a, or_rd_a} !== {1'b1, pat(i - 1)}) begin
                    errors++; $display("FAIL burst_or addr %0d got %h exp %h", i - 1, {or_rv_a, or_rd_a}, {1'b1, pat(i - 1)});
                end
            end
            if (i == 65) begin
                checks++;
                if ({or_rv_a, or_rd_a} !== {1'b0, pat(63)}) begin
                    errors++; $display("FAIL burst_or_drain got %h exp %h", {or_rv_a, or_rd_a}, {1'b0, pat(63)});
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            en_a = 1'b1; addr_a = 6'(i);
            step();
        end
        checks++;
        if ({or_rv_a, or_rd_a} !== {1'b1, pat(1)}) begin
            errors++; $display("FAIL pre_reset_or got %h exp %h", {or_rv_a, or_rd_a}, {1'b1, pat(1)});
        end
        rst = 1'b1; en_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
        addr_a = 6'd5; addr_b = 6'd5; wd_a = 16'hDEAD; wd_b = 16'hBEEF;
        step();
        checks++;
        if ({or_rv_a, or_rd_a, or_col} !== 18'd0) begin
            errors++; $display("FAIL mid_reset_or got %h exp 0", {or_rv_a, or_rd_a, or_col});
        end
        checks++;
        if ({d0_rv_a, d0_rd_a, d0_rv_b, d0_rd_b} !== 34'd0) begin
            errors++; $display("FAIL mid_reset_d0 got %h exp 0", {d0_rv_a, d0_rd_a, d0_rv_b, d0_rd_b});
        end
        step();
        checks++;
        if (d0_col !== 1'b0) begin errors++; $display("FAIL reset_no_col got %b exp 0", d0_col); end
        rst = 1'b0; idle(); en_a = 1'b1; addr_a = 6'd5;
        step();
        checks++;
        if (d0_rd_a !== pat(5)) begin errors++; $display("FAIL preserved_d0 got %h exp %h", d0_rd_a, pat(5)); end
        idle();
        step();
        checks++;
        if ({or_rv_a, or_rd_a} !== {1'b1, pat(5)}) begin
            errors++; $display("FAIL preserved_or got %h exp %h", {or_rv_a, or_rd_a}, {1'b1, pat(5)});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_en();
        test_read_mode();
        test_collision();
        test_output_reg();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/true_dual_port_ram_sync.md
# true_dual_port_ram_sync

Parametrised, byte-writable, true dual-port synchronous RAM with two fully independent read/write ports (A, B) on a single clock. Successor to the fixed 64×16 one-write/two-read RAM: adds per-port write, byte enables, selectable read-during-write mode, an optional output register stage with read-valid tracking, and write-collision detection. Used as the shared scratch/buffer memory between two datapath engines in the FPGA lab designs.

## Interface
- DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH
- BYTE_WIDTH, 8, bits per byte-enable lane
- OUTPUT_REG, 0, 0 = read latency 1, 1 = extra output register, latency 2
- READ_MODE, 0, same-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data)

Ports:
- clockPulse  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears output/valid state only
- enableA / enableB  in  1  port access enable
- writeEnableA / writeEnableB  in  1  write when enable also high
- byteEnableA / byteEnableB  in  DATA_WIDTH/BYTE_WIDTH  per-lane write mask
- addressA / addressB  in  ADDR_WIDTH  word address
- writeDataA / writeDataB  in  DATA_WIDTH  write data
- readDataA / readDataB  out  DATA_WIDTH  read data
- readValidA / readValidB  out  1  readData holds the result of an accepted access
- collision  out  1  registered pulse: both ports wrote the same address in the previous cycle

## Operation
- Access accepted on rising edge when enableX=1 and reset=0. Every accepted access (read or write) returns a word on readDataX.
- Write: lanes with byteEnableX[i]=1 updated; other lanes keep old contents. writeEnableX=1 with byteEnableX all zero is a read.
- Same-port read-during-write: READ_MODE=0 returns pre-write word; READ_MODE=1 returns merged post-write word (only enabled lanes new).
- Cross-port read of an address the other port writes in the same cycle: always returns the old word.
- Both ports write same address same cycle: lanes enabled on both take port A data; lanes enabled on only one port take that port's data; collision=1 the next cycle. Same-address reads on both ports, or read+write, never raise collision.
- enableX=0: readDataX holds last value; readValidX drops to 0 at the corresponding latency.
- Memory array is not cleared by reset (contents undefined at power-up in simulation: X).
- While reset=1: no writes performed, no accesses accepted.

## Timing
- Reset values: readDataA/B = 0, readValidA/B = 0, collision = 0; the output pipeline register (OUTPUT_REG=1) is also cleared.
- Latency OUTPUT_REG=0: access at edge N -> readData/readValid valid after edge N+1... precisely, registered at edge N, visible through cycle N+1.
- Latency OUTPUT_REG=1: one further edge; readValid delayed identically to data.
- Back-to-back accesses every cycle at full throughput on both ports; no stalls.
- Reset asserted mid-stream: accesses in flight are dropped; outputs read 0/valid 0 after the first edge with reset=1, including the pipeline stage.
- collision asserted for exactly one cycle per colliding cycle; back-to-back collisions keep it high.
- Address wrap: none; all 2**ADDR_WIDTH addresses valid, address 2**ADDR_WIDTH-1 behaves normally.

## Structure
- Package ram_pkg: READ_FIRST=0, WRITE_FIRST=1 constants; function computing lane count DATA_WIDTH/BYTE_WIDTH.
- Sub-module ram_port_pipe: per-port output stage (data + valid register, bypassed when OUTPUT_REG=0, synchronous reset), instantiated twice.
- Elaboration check: error when DATA_WIDTH mod BYTE_WIDTH ≠ 0.

## Test plan
- Defaults, reset 3 cycles: write A addr 4 = 0xB0CB, read B addr 4 next cycle -> readDataB=0xB0CB, readValidB=1 one cycle after read accepted.
- Byte enables: addr 7 = 0x3838, write A 0x1C1C with byteEnableA=2'b01 -> read returns 0x381C.
- READ_MODE=0 vs 1: addr 8 = 0x1111, port A writes 0x2222 and reads same cycle -> 0x1111 (mode 0) / 0x2222 (mode 1); port B reading addr 8 same cycle -> 0x1111 in both.
- Collision: A writes 0xAAAA, B writes 0x5555 to addr 11 full mask -> collision=1 for one cycle, later read = 0xAAAA; B lane-only 2'b10 with A 2'b01 -> 0x55AA, collision=1.
- OUTPUT_REG=1: continuous reads addr 0..63 on A -> data/valid arrive exactly 2 edges after each access, no gaps, addr 63 correct.
- Reset mid-read burst (OUTPUT_REG=1): readData/readValid/collision = 0 after first reset edge; memory contents preserved after reset release.
